// File: rtl/fib_ctrl.sv
// fib_ctrl: request/response front end for the fib sequence core.
//
// Takes an index n over a valid/ready handshake, strobes it into the core,
// waits for the core's busy flag to drop, captures the WIDTH-bit result and
// streams it out LSB-first as bytes over a valid/ready byte channel.
//
// Ports:
//   i_clk, i_reset        clock; asynchronous active-high reset
//   i_valid, o_ready, i_n request channel (o_ready high only when idle)
//   o_fib_stb, o_fib_n    core strobe (one cycle) and latched index
//   i_fib_busy            core busy flag
//   i_fib_value           core result
//   o_valid, i_ready      output byte channel handshake
//   o_data, o_last        output byte and final-byte marker
//   o_busy                high whenever a request is in progress
//
// WIDTH must be a multiple of 8.
module fib_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_n,
    output logic             o_fib_stb,
    output logic [WIDTH-1:0] o_fib_n,
    input  logic             i_fib_busy,
    input  logic [WIDTH-1:0] i_fib_value,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [7:0]       o_data,
    output logic             o_last,
    output logic             o_busy
);

    localparam int unsigned BYTES = WIDTH / 8;
    localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StSettle,
        StWait,
        StSend
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] n_q;
    logic [WIDTH-1:0] res_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;
    logic [7:0]       next_byte;
    logic             ready_q;
    logic             stb_q;
    logic             valid_q;
    logic             last_q;
    logic             busy_q;
    logic [7:0]       data_q;

    // Byte that follows the one currently presented; only used while not last.
    always_comb begin
        idx_d     = idx_q + 1'b1;
        next_byte = res_q[{idx_d, 3'b000} +: 8];
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= StIdle;
            n_q     <= '0;
            res_q   <= '0;
            idx_q   <= '0;
            ready_q <= 1'b1;
            stb_q   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_valid) begin
                        n_q     <= i_n;
                        ready_q <= 1'b0;
                        stb_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    stb_q   <= 1'b0;
                    state_q <= StSettle;
                end
                // The core's busy flag is first meaningful here; n=0 never raises it.
                StSettle, StWait: begin
                    if (!i_fib_busy) begin
                        res_q   <= i_fib_value;
                        data_q  <= i_fib_value[7:0];
                        idx_q   <= '0;
                        last_q  <= (BYTES == 1);
                        valid_q <= 1'b1;
                        state_q <= StSend;
                    end else begin
                        state_q <= StWait;
                    end
                end
                StSend: begin
                    if (i_ready) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            data_q  <= '0;
                            idx_q   <= '0;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            idx_q  <= idx_d;
                            data_q <= next_byte;
                            last_q <= (idx_d == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign o_ready   = ready_q;
    assign o_fib_stb = stb_q;
    assign o_fib_n   = n_q;
    assign o_valid   = valid_q;
    assign o_data    = data_q;
    assign o_last    = last_q;
    assign o_busy    = busy_q;

endmodule

// File: doc/fib_ctrl.md
# fib_ctrl

Request/response front end for the fib sequence core: accepts an index `n` over a valid/ready handshake, drives the core's strobe/index inputs, tracks its busy flag until the computation finishes, captures the `WIDTH`-bit result, and streams it out as bytes, LSB first, over a valid/ready byte channel. It sits directly upstream of the core, feeding `i_stb`/`i_n`, and directly downstream of it, consuming `o_busy`/`o_fib`.

## Interface
- `WIDTH`, 32, width of `n` and of the result; must be a multiple of 8; `BYTES = WIDTH/8`.
- `i_clk` in 1: single clock shared with the fib core.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_valid` in 1: request valid.
- `o_ready` out 1: request accepted when `i_valid && o_ready` at a rising edge.
- `i_n` in `WIDTH`: requested index, sampled on acceptance.
- `o_fib_stb` out 1: strobe to the core's `i_stb`.
- `o_fib_n` out `WIDTH`: index to the core's `i_n`.
- `i_fib_busy` in 1: from the core's `o_busy`.
- `i_fib_value` in `WIDTH`: from the core's `o_fib`.
- `o_valid` out 1: output byte valid.
- `i_ready` in 1: downstream accepts a byte when `o_valid && i_ready`.
- `o_data` out 8: output byte.
- `o_last` out 1: high with the final byte (index `BYTES-1`).
- `o_busy` out 1: high whenever state is not IDLE.

## Operation
- **States:**
  - IDLE: `o_ready=1`. On accept, latch `i_n` into `n_reg` and go to ISSUE.
  - ISSUE: `o_fib_stb=1` for exactly one cycle, then go to SETTLE.
  - SETTLE: one cycle, during which the core's busy flag becomes valid. If `i_fib_busy=0`, capture `i_fib_value` and go to SEND. Otherwise go to WAIT.
  - WAIT: hold while `i_fib_busy=1`. On the first cycle `i_fib_busy=0`, capture `i_fib_value` into `res_reg`, clear the byte index, and go to SEND.
  - SEND: `o_valid=1`, `o_data=res_reg[8*idx +: 8]`, `o_last=(idx==BYTES-1)`. Each handshake increments `idx`. A handshake while `o_last` is high returns the block to IDLE.
- **Outputs by state:**
  - `o_fib_n = n_reg` at all times.
  - `o_fib_stb` is high only in ISSUE. The core is guaranteed idle at that point.
  - `o_ready` is high only in IDLE; `i_valid` in any other state is ignored.
- **Backpressure:** in SEND with `i_ready=0`, `o_data`, `o_last` and `o_valid` hold stable.
- **n=0:** the core never raises busy. SETTLE sees busy low and captures the value 0.
- **Reset values:** state IDLE, `o_ready=1`, `o_fib_stb=0`, `o_valid=0`, `o_last=0`, `o_data=0`, `o_busy=0`, `n_reg=0`, `res_reg=0`, `idx=0`.
- **Reset mid-operation:** the block returns to IDLE asynchronously, and any partially sent result is dropped. The core's own synchronous reset is driven from the same net at top level; this block does not depend on it.
- **Arithmetic:** `idx` is `$clog2(BYTES)` bits wide, with a minimum width of 1. The result is passed through unchanged, modulo 2^`WIDTH`.

## Timing
- The request is accepted at edge T.
- ISSUE occupies cycle T+1, and the core loads at the end of it.
- SETTLE occupies cycle T+2.
- For n=k>0, the core is busy during cycles T+2..T+k+1. Busy reads low in T+k+2, the result is captured at the end of that cycle, and the first byte is valid in T+k+3.
- For n=0, the capture happens at the end of T+2 and the first byte is valid in T+3.
- With `i_ready` held high, the output occupies `BYTES` consecutive cycles and `o_ready` rises the cycle after the last handshake.
- Minimum request-to-request spacing is k+3+`BYTES` cycles.

## Test plan
- **Reset values:** assert reset asynchronously between clock edges, then check every output against its listed reset value before the next edge.
- **n=0:** accept at T, then check that `o_fib_stb` is high only in T+1 and that bytes 00 00 00 00 appear in T+3..T+6, with `o_last` high in T+6.
- **n=1, real core attached:** expect the result 0xFFFFFFFD, sent as bytes FD FF FF FF with the first byte in T+4.
- **n=2, real core attached:** expect the result 0x00000015, sent as bytes 15 00 00 00 with the first byte in T+5. While busy, drive `i_valid` and check that `o_ready` stays 0 and the request is not accepted.
- **Backpressure:** with n=1, hold `i_ready=0` for 3 cycles on byte 1. `o_data` must stay FF and `o_valid` must stay 1, with no byte lost or duplicated.
- **Reset mid-WAIT:** with n=10, assert reset in T+5. The block returns to IDLE immediately with `o_valid=0`. After reset is released, a new n=2 request produces 15 00 00 00.
